// File: rtl/instr_entry_queue.sv
// instr_entry_queue: decodes ARM instructions to microcode entry addresses into a FIFO.
// Ports: clk/reset/flush, in_valid/in_ready/in_instr, out_valid/out_ready/out_* head, count.
module instr_entry_queue #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] UNDEF_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_entry,
  output logic                     out_undef,
  output logic [3:0]               out_cond,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] r_entry [DEPTH];
  logic              r_undef [DEPTH];
  logic [31:0]       r_instr [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic [2:0]        w_op;
  logic [3:0]        w_ls;
  logic              w_br;
  logic              w_dpi;
  logic              w_dpr;
  logic              w_hw;
  logic              w_ldst;
  logic [7:0]        w_raw;
  logic [ADDR_W-1:0] w_entry;
  logic              w_undef;
  logic              w_push;
  logic              w_pop;

  assign w_op = in_instr[27:25];
  // load/store mode bits: {L, P, U, W}
  assign w_ls = {in_instr[20], in_instr[24],
                 in_instr[23], in_instr[21]};

  assign w_br   = (w_op == 3'b101);
  assign w_dpi  = (w_op == 3'b001);
  assign w_dpr  = (w_op == 3'b000) && !in_instr[4];
  assign w_hw   = (w_op == 3'b000) && in_instr[7]
               && in_instr[4]
               && (in_instr[6:5] != 2'b00);
  assign w_ldst = (w_op == 3'b010);

  // Classes are mutually exclusive, so order is free.
  always_comb begin
    w_raw   = 8'd0;
    w_undef = 1'b0;
    unique case (1'b1)
      w_br:    w_raw = in_instr[24] ? 8'd40 : 8'd42;
      w_dpi:   w_raw = 8'd43;
      w_dpr:   w_raw = 8'd44;
      w_hw:    w_raw = 8'd45 + {4'd0, w_ls};
      w_ldst:  w_raw = 8'd4 + {3'd0, w_ls, 1'b0};
      default: w_undef = 1'b1;
    endcase
  end

  // All legal entries are < 64, so the narrowest ADDR_W (7) holds them.
  assign w_entry = w_undef ? UNDEF_ADDR : ADDR_W'(w_raw);

  assign in_ready  = !reset && !flush && (r_count < FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop && !w_push)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entry[r_wptr] <= w_entry;
      r_undef[r_wptr] <= w_undef;
      r_instr[r_wptr] <= in_instr;
    end
  end

  // Storage is never cleared; gating keeps the head at 0 when empty.
  assign out_entry = out_valid ? r_entry[r_rptr] : '0;
  assign out_undef = out_valid ? r_undef[r_rptr] : 1'b0;
  assign out_instr = out_valid ? r_instr[r_rptr] : 32'd0;
  assign out_cond  = out_instr[31:28];
  assign count     = r_count;

endmodule
